comp_engine: RTL
================

Name: comp_engine

Overview:
- Dictionary-based compression/decompression responder; it is the DUT end of the compression interface.
- It accepts COMPRESS/DECOMPRESS commands and returns compressed_out, decompressed_out and a 2-bit response.
- COMPRESS maps a data word to a dictionary index, allocating a new entry on a miss. DECOMPRESS maps an index back to its data word.
- Lookup is a sequential scan, one entry per cycle, so latency depends on dictionary contents.

Parameters:
- DATA_WIDTH, 8, width of data and compressed words.
- DICT_DEPTH, 16, number of dictionary entries; power of 2, at least 2, and clog2(DICT_DEPTH) must not exceed DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  word to compress.
- compressed_in  in  DATA_WIDTH  index to decompress.
- command  in  2  00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 RSVD.
- compressed_out  out  DATA_WIDTH  index result, zero-extended.
- decompressed_out  out  DATA_WIDTH  data result.
- response  out  2  00 IDLE, 01 OK, 10 ERR, 11 BUSY.

Behaviour:
- Reset:
  - State goes to IDLE; count=0; evict_ptr=0.
  - compressed_out=0, decompressed_out=0, response=00.
  - Dictionary storage is not cleared; count invalidates all entries.
  - Reset in any state aborts the operation; no OK/ERR is emitted.
- States: IDLE, SEARCH, LOOKUP, RESP.
- IDLE:
  - response=00.
  - Command is sampled only here. At cycle T with a non-NOP command, data_in/compressed_in are registered.
  - COMPRESS goes to SEARCH with ptr=0. DECOMPRESS goes to LOOKUP. RSVD goes to RESP with ERR.
- SEARCH / LOOKUP:
  - response=11 (BUSY).
  - Commands and inputs are ignored.
- SEARCH, one entry per cycle at ptr:
  - If ptr<count and dict[ptr]==data: hit. Result=ptr, go to RESP with OK.
  - If ptr<count and no match: ptr++.
  - If ptr==count and count<DICT_DEPTH: write dict[count]=data, count++, result=old count, go to RESP with OK.
  - If ptr==count==DICT_DEPTH: go to RESP with ERR.
- COMPRESS latency: OK/ERR appears at cycle T+2+k.
  - k = hit index, allocated index, or DICT_DEPTH when full.
  - Empty dictionary gives OK at T+2.
- LOOKUP, one cycle:
  - If the upper bits of compressed_in above the index width are nonzero, or idx>=count: ERR.
  - Otherwise result=dict[idx], OK.
  - Response at T+2.
- RESP, one cycle:
  - response=01 or 10.
  - On OK, the matching output register (compressed_out or decompressed_out) updates in this same cycle.
  - On ERR, both outputs hold their previous values.
  - Next state is always IDLE; a command present during the RESP cycle is ignored.
  - Minimum command spacing is therefore 3 cycles (T, T+1 busy, T+2 resp, next command at T+3).
- Outputs hold their last OK value indefinitely.
- Duplicate data is never inserted, because a hit always precedes allocation.

Optional Feature:
- Macro: COMP_RR_EVICT_EN.
- Defined: a COMPRESS miss on a full dictionary overwrites dict[evict_ptr] and responds OK with compressed_out=evict_ptr, at T+2+DICT_DEPTH. evict_ptr then increments modulo DICT_DEPTH.
- Undefined: the full-dictionary miss responds ERR, and no evict_ptr register exists.

Decomposition:
- Package comp_pkg holds:
  - cmd_e: CMD_NOP, CMD_COMPRESS, CMD_DECOMPRESS, CMD_RSVD.
  - rsp_e: RSP_IDLE, RSP_OK, RSP_ERR, RSP_BUSY.
  - state_e.
- One sub-module, comp_dict: DICT_DEPTH x DATA_WIDTH register array with one synchronous write port and one combinational read port. It has no reset on its contents.
- The FSM, count, ptr and evict_ptr stay in comp_engine.

Test Plan (DATA_WIDTH=8, DICT_DEPTH=4):
- Reset, COMPRESS 0xA5 at T: response 11 at T+1, 01 at T+2 with compressed_out=0x00. Then COMPRESS 0x3C: 01 at T'+3 with compressed_out=0x01.
- COMPRESS 0xA5 again: hit, OK at T+2, compressed_out=0x00. A following COMPRESS 0x77 returns 0x02, proving count did not grow on the hit.
- DECOMPRESS 0x01: OK at T+2, decompressed_out=0x3C. DECOMPRESS 0x03 (unallocated) and DECOMPRESS 0x04 (upper bits set): each ERR at T+2, decompressed_out holds 0x3C.
- Fill the dictionary with 0x10..0x13, then COMPRESS 0x99:
  - Macro off: ERR at T+6, compressed_out unchanged.
  - Macro on: OK at T+6, compressed_out=0x00; then DECOMPRESS 0x00 returns 0x99.
- Hold command=COMPRESS (data 0x55) continuously: exactly one response per 3+k cycles, and no response while BUSY. RSVD command: ERR at T+1.
- Assert reset at T+2 of a SEARCH on a 3-entry dictionary: response 00 after reset. Then DECOMPRESS 0x00 gives ERR, and COMPRESS 0x10 gives index 0x00.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared command, response and state encodings for the dictionary compression engine.
package comp_pkg;

    typedef enum logic [1:0] {
        CMD_NOP        = 2'b00,
        CMD_COMPRESS   = 2'b01,
        CMD_DECOMPRESS = 2'b10,
        CMD_RSVD       = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_OK   = 2'b01,
        RSP_ERR  = 2'b10,
        RSP_BUSY = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_LOOKUP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/comp_dict.sv
// Dictionary storage: DICT_DEPTH x DATA_WIDTH registers, one synchronous write port
// and one combinational read port.
module comp_dict #(
    parameter int DATA_WIDTH = 8,
    parameter int DICT_DEPTH = 16,
    localparam int IDX_W     = $clog2(DICT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DICT_DEPTH];

    // NOTE: no reset on the array; the engine's entry count marks which words are valid,
    // so clearing storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/comp_engine.sv
// Dictionary compression responder: sequential-scan COMPRESS, indexed DECOMPRESS.
// Optional macro COMP_RR_EVICT_EN enables round-robin eviction when the dictionary is full.
module comp_engine
    import comp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DICT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] compressed_in,
    input  logic [1:0]            command,
    output logic [DATA_WIDTH-1:0] compressed_out,
    output logic [DATA_WIDTH-1:0] decompressed_out,
    output logic [1:0]            response
);

    localparam int IDX_W = $clog2(DICT_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DICT_DEPTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] cin_q, cin_d;
    logic [DATA_WIDTH-1:0] cout_q, cout_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  err_q, err_d;
`ifdef COMP_RR_EVICT_EN
    logic [IDX_W-1:0]      evict_q, evict_d;
`endif

    cmd_e                  cmd;
    rsp_e                  rsp;
    logic                  wr_en;
    logic [IDX_W-1:0]      waddr;
    logic [IDX_W-1:0]      raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  idx_bad;

    assign cmd = cmd_e'(command);

    // The single read port serves the scan pointer in SEARCH and the requested index otherwise.
    assign raddr   = (state_q == ST_SEARCH) ? ptr_q[IDX_W-1:0] : cin_q[IDX_W-1:0];
    assign idx_bad = ((cin_q >> IDX_W) != '0) || ({1'b0, cin_q[IDX_W-1:0]} >= count_q);

    comp_dict #(
        .DATA_WIDTH (DATA_WIDTH),
        .DICT_DEPTH (DICT_DEPTH)
    ) u_dict (
        .clk   (clk),
        .we    (wr_en && !reset),
        .waddr (waddr),
        .wdata (data_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        data_d  = data_q;
        cin_d   = cin_q;
        cout_d  = cout_q;
        dout_d  = dout_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        waddr   = count_q[IDX_W-1:0];
        rsp     = RSP_IDLE;
`ifdef COMP_RR_EVICT_EN
        evict_d = evict_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                rsp = RSP_IDLE;
                if (cmd != CMD_NOP) begin
                    data_d = data_in;
                    cin_d  = compressed_in;
                end
                unique case (cmd)
                    CMD_COMPRESS: begin
                        state_d = ST_SEARCH;
                        ptr_d   = '0;
                    end
                    CMD_DECOMPRESS: state_d = ST_LOOKUP;
                    CMD_RSVD: begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_SEARCH: begin
                rsp = RSP_BUSY;
                if (ptr_q < count_q) begin
                    if (rdata == data_q) begin
                        cout_d  = DATA_WIDTH'(ptr_q);
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        ptr_d = ptr_q + CNT_W'(1);
                    end
                end else if (count_q < DEPTH_C) begin
                    wr_en   = 1'b1;
                    cout_d  = DATA_WIDTH'(count_q);
                    count_d = count_q + CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
`ifdef COMP_RR_EVICT_EN
                    wr_en   = 1'b1;
                    waddr   = evict_q;
                    cout_d  = DATA_WIDTH'(evict_q);
                    evict_d = evict_q + IDX_W'(1);
                    err_d   = 1'b0;
`else
                    err_d   = 1'b1;
`endif
                    state_d = ST_RESP;
                end
            end

            ST_LOOKUP: begin
                rsp     = RSP_BUSY;
                state_d = ST_RESP;
                if (idx_bad) begin
                    err_d = 1'b1;
                end else begin
                    dout_d = rdata;
                    err_d  = 1'b0;
                end
            end

            ST_RESP: begin
                rsp     = err_q ? RSP_ERR : RSP_OK;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            cin_q   <= '0;
            cout_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
`ifdef COMP_RR_EVICT_EN
            evict_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            cin_q   <= cin_d;
            cout_q  <= cout_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
`ifdef COMP_RR_EVICT_EN
            evict_q <= evict_d;
`endif
        end
    end

    assign compressed_out   = cout_q;
    assign decompressed_out = dout_q;
    assign response         = rsp;

endmodule
